// File: rtl/opti_sos_cascade_ctrl.sv
// Sequencer that time-multiplexes one opti_sos_stage across NUM_SECTIONS biquad
// sections, owning the coefficient bank and gain register.
module opti_sos_cascade_ctrl #(
  parameter int unsigned NUM_SECTIONS = 4,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  input  logic        cfg_wr_en,
  input  logic [2:0]  cfg_wr_sec,
  input  logic [2:0]  cfg_wr_sel,
  input  logic [15:0] cfg_wr_data,
  output logic        stg_valid_in,
  output logic [15:0] stg_data_in,
  output logic        stg_is_last,
  output logic [15:0] stg_gain,
  output logic [15:0] stg_b0,
  output logic [15:0] stg_b1,
  output logic [15:0] stg_b2,
  output logic [15:0] stg_a1,
  output logic [15:0] stg_a2,
  input  logic        stg_valid_out,
  input  logic [15:0] stg_data_out,
  output logic        busy,
  output logic [2:0]  sec_idx,
  output logic        err_timeout,
  output logic        err_cfg
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]  LAST_SEC = 3'(NUM_SECTIONS - 1);
  localparam logic [15:0] GAIN_ONE = 16'h2000;

  state_t        state_q, state_d;
  logic [15:0]   work_q, work_d;
  logic [15:0]   out_data_q, out_data_d;
  logic [15:0]   gain_q, gain_d;
  logic [2:0]    sec_q, sec_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          out_valid_q, out_valid_d;
  logic          svo_prev_q;
  logic          err_timeout_q, err_timeout_d;
  logic          err_cfg_q, err_cfg_d;
  logic [15:0]   coef_q [8][5];
  logic [15:0]   coef_d [8][5];

  logic accept, done, timed_out;

  // Completion is the rising edge of the stage valid, so a held level counts once.
  assign accept    = (state_q == S_IDLE) && in_valid;
  assign done      = stg_valid_out && !svo_prev_q;
  assign timed_out = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      work_q        <= '0;
      out_data_q    <= '0;
      gain_q        <= GAIN_ONE;
      sec_q         <= '0;
      tmo_q         <= '0;
      out_valid_q   <= 1'b0;
      svo_prev_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_cfg_q     <= 1'b0;
      coef_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      out_data_q    <= out_data_d;
      gain_q        <= gain_d;
      sec_q         <= sec_d;
      tmo_q         <= tmo_d;
      out_valid_q   <= out_valid_d;
      svo_prev_q    <= stg_valid_out;
      err_timeout_q <= err_timeout_d;
      err_cfg_q     <= err_cfg_d;
      coef_q        <= coef_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (done)           state_d = (sec_q == LAST_SEC) ? S_OUTPUT : S_ISSUE;
        else if (timed_out) state_d = S_IDLE;
      end
      S_OUTPUT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    work_d        = work_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    sec_d         = sec_q;
    tmo_d         = tmo_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        work_d = in_data;
        sec_d  = '0;
      end
      S_ISSUE: tmo_d = '0;
      S_WAIT: begin
        if (done) begin
          work_d = stg_data_out;
          if (sec_q == LAST_SEC) begin
            out_data_d  = stg_data_out;
            out_valid_d = 1'b1;
          end else begin
            sec_d = sec_q + 3'd1;
          end
        end else if (timed_out) begin
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_OUTPUT: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    gain_d    = gain_q;
    coef_d    = coef_q;
    err_cfg_d = err_cfg_q;
    if (cfg_wr_en) begin
      if ((state_q != S_IDLE) || accept || (cfg_wr_sel >= 3'd6)) begin
        err_cfg_d = 1'b1;
      end else if (cfg_wr_sel == 3'd5) begin
        gain_d = cfg_wr_data;
      end else if (32'(cfg_wr_sec) < NUM_SECTIONS) begin
        coef_d[cfg_wr_sec][cfg_wr_sel] = cfg_wr_data;
      end
    end
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    stg_valid_in = (state_q == S_ISSUE);
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign stg_data_in = work_q;
  assign stg_is_last = (sec_q == LAST_SEC);
  assign stg_gain    = gain_q;
  assign stg_b0      = coef_q[sec_q][0];
  assign stg_b1      = coef_q[sec_q][1];
  assign stg_b2      = coef_q[sec_q][2];
  assign stg_a1      = coef_q[sec_q][3];
  assign stg_a2      = coef_q[sec_q][4];
  assign sec_idx     = sec_q;
  assign err_timeout = err_timeout_q;
  assign err_cfg     = err_cfg_q;

endmodule

// File: doc/opti_sos_cascade_ctrl.md
Name: opti_sos_cascade_ctrl

Overview:
Sequencer that sits directly upstream of one opti_sos_stage instance and time-multiplexes it across NUM_SECTIONS biquad sections.
- Accepts Q2.13 samples over a valid/ready handshake.
- Holds the per-section coefficient bank and the gain-correction register.
- Feeds the stage one section at a time, chaining each section's output into the next.
- Asserts is_last_stage on the final section.
- Presents the cascade result on a valid/ready output.

Parameters:
NUM_SECTIONS, 4, number of cascaded biquad sections (1..8).
TIMEOUT_CYC, 64, max cycles to wait for stage completion before aborting the sample.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_data  in  16  input sample, Q2.13
out_valid  out  1  cascade result valid, held until accepted
out_ready  in  1  downstream accepts result
out_data  out  16  cascade result, Q2.13
cfg_wr_en  in  1  coefficient write strobe
cfg_wr_sec  in  3  section index for write
cfg_wr_sel  in  3  0=b0 1=b1 2=b2 3=a1 4=a2 5=gain (sec ignored) 6,7=reserved
cfg_wr_data  in  16  coefficient value, Q2.13
stg_valid_in  out  1  one-cycle start pulse to stage
stg_data_in  out  16  sample for current section
stg_is_last  out  1  current section is NUM_SECTIONS-1
stg_gain  out  16  gain-correction register
stg_b0, stg_b1, stg_b2, stg_a1, stg_a2  out  16 each  current section coefficients
stg_valid_out  in  1  stage result valid
stg_data_out  in  16  stage result
busy  out  1  sample in flight (state != IDLE)
sec_idx  out  3  section currently being processed
err_timeout  out  1  sticky: a stage call timed out
err_cfg  out  1  sticky: write attempted while busy or with sel 6/7

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE. Outputs in_ready=1, out_valid=0, out_data=0, stg_valid_in=0, stg_data_in=0, sec_idx=0, busy=0, err_timeout=0, err_cfg=0.
  - All coefficients clear to 0. Gain resets to 16'h2000 (1.0).
  - Reset mid-operation abandons the sample silently; any late stg_valid_out after reset is ignored.
- States: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the work register, set sec_idx=0, go to ISSUE.
- ISSUE:
  - Drive stg_valid_in=1 for exactly one cycle, with stg_data_in = work register.
  - Clear the timeout counter, go to WAIT.
- WAIT:
  - Detect completion on the rising edge of stg_valid_out (registered previous value), so a level held for 2 cycles counts once.
  - On completion: work register <= stg_data_out.
    - If sec_idx == NUM_SECTIONS-1: out_data <= stg_data_out, out_valid <= 1, go to OUTPUT.
    - Otherwise: sec_idx++, go to ISSUE.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT_CYC without completion: set err_timeout, go to IDLE, no output produced.
- OUTPUT:
  - Hold out_valid and out_data stable until out_ready=1, then clear out_valid and go to IDLE.
  - in_ready=0 here. The next sample is accepted only in IDLE (one-cycle bubble minimum).
- in_ready is 1 only in IDLE. A stg_valid_out pulse outside WAIT is ignored.
- Coefficient outputs are combinational muxes of the bank indexed by sec_idx. stg_is_last = (sec_idx == NUM_SECTIONS-1).
- Config writes:
  - Applied at the clock edge only when busy=0 and sel<=5.
  - A write with busy=1 or sel>=6 is dropped and sets err_cfg.
  - A write with cfg_wr_sec >= NUM_SECTIONS is dropped silently.
  - A write coinciding with an IDLE->ISSUE accept is dropped and flagged.
- Sticky error flags clear only on rst.
- Per-section latency = 1 (ISSUE) + stage latency + 1 (edge detect/capture).
- Sample latency from in accept to out_valid = NUM_SECTIONS * per-section latency + 1.
- The controller does no arithmetic. Saturation and gain multiply are done in the stage.

Test Plan:
- Identity cascade:
  - Set all b0=16'h2000, others 0, gain 16'h2000; in_data=16'h1000.
  - Expect exactly 4 stg_valid_in pulses with stg_is_last=1 only on the 4th, and out_data=16'h1000 with out_valid held.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid rises.
  - Expect out_valid/out_data stable, in_ready=0 and in_valid ignored; out_ready=1 for 1 cycle returns to IDLE with in_ready=1 the next cycle.
- Timeout:
  - Stub the stage to never assert stg_valid_out.
  - Expect err_timeout=1 exactly TIMEOUT_CYC=64 cycles into WAIT, state IDLE, out_valid never asserted.
- Config while busy:
  - Write b0 of section 2 = 16'h1000 mid-sample.
  - Expect bank unchanged (readback via sec_idx=2 still 16'h2000) and err_cfg=1.
- Reset mid-operation:
  - Assert rst during WAIT of section 2 while the stage later fires stg_valid_out.
  - Expect all outputs at reset values, no out_valid, and the next sample processed correctly from section 0.
- Held stage valid:
  - Stage holds stg_valid_out for 2 cycles.
  - Expect a single section advance per sample per section (sec_idx increments once).
